// File: rtl/stepper_pulse_sched.sv
// Step-pulse scheduler: issues a burst of fixed-width step pulses at a
// programmable period, with abort, completion strobe and remaining-step count.
module stepper_pulse_sched #(
  parameter int CNT_W     = 28,
  parameter int STEP_W    = 16,
  parameter int PULSE_CYC = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  period,
  input  logic [STEP_W-1:0] steps,
  input  logic              dir_in,
  input  logic              abort,
  output logic              step,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left
);

  // state | meaning
  // IDLE  | waiting for a command, step low
  // HIGH  | step pulse high for PULSE_CYC cycles
  // LOW   | step low for the remainder of the effective period
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_W   = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] PULSE_MIN = CNT_W'(PULSE_CYC + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   p_eff_q, p_eff_d;
  logic [STEP_W-1:0]  left_q, left_d;
  logic               dir_q, dir_d;
  logic               step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   low_last;

  // Last timer value of the LOW phase; P_eff >= PULSE_CYC+1 keeps this non-negative.
  assign low_last = p_eff_q - PULSE_MIN;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    p_eff_d = p_eff_q;
    left_d  = left_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          p_eff_d = (period > PULSE_W) ? period : PULSE_MIN;
          left_d  = steps;
          dir_d   = dir_in;
          timer_d = '0;
          if (steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_HIGH;
          end
        end
      end

      S_HIGH: begin
        if (abort) begin
          state_d = S_IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end else if (timer_q == HIGH_LAST) begin
          state_d = S_LOW;
          timer_d = '0;
          left_d  = left_q - STEP_W'(1);
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      S_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end else if (timer_q == low_last) begin
          timer_d = '0;
          if (left_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_HIGH;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // Outputs are registered from the next state so they never glitch.
    step_d = (state_d == S_HIGH);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      p_eff_q <= '0;
      left_q  <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      p_eff_q <= p_eff_d;
      left_q  <= left_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = left_q;

endmodule

// File: tb/tb_stepper_pulse_sched.sv
// Randomized and directed bench for stepper_pulse_sched; outputs are compared
// every cycle against a closed-form timing model of the command.
module tb_stepper_pulse_sched;
  localparam int CNT_W  = 28;
  localparam int STEP_W = 16;
  localparam int PC     = 4;
  localparam int NONE   = 1 << 30;

  logic              clk;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  period;
  logic [STEP_W-1:0] steps;
  logic              dir_in;
  logic              abort;
  logic              step;
  logic              dir;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_left;

  int errors = 0;
  int checks = 0;
  logic [19:0] obs [0:399];

  stepper_pulse_sched #(
    .CNT_W(CNT_W), .STEP_W(STEP_W), .PULSE_CYC(PC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .period(period), .steps(steps),
    .dir_in(dir_in), .abort(abort), .step(step), .dir(dir), .busy(busy),
    .done(done), .steps_left(steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int peff(int p);
    return (p > PC) ? p : PC + 1;
  endfunction

  // Pulses completed after t cycles of a command: pulse i falls at t = i*p+PC.
  function automatic int left_at(int t, int n, int p);
    return n - ((t >= PC) ? ((t - PC) / p + 1) : 0);
  endfunction

  // Expected {step,busy,done,dir,steps_left} t cycles after the command takes
  // effect (t=0 is the first cycle after the accepting edge); ta = abort time.
  function automatic logic [19:0] model(int t, int n, int p, bit d, int ta);
    logic s, b, dn;
    int lf;
    s = 1'b0; b = 1'b0; dn = 1'b0; lf = 0;
    if (t < 0) return 20'h0;
    if (ta != NONE && t > ta) begin
      lf = left_at(ta, n, p);
      dn = (t == ta + 1);
    end else if (n == 0) begin
      dn = (t == 0);
    end else if (t < n * p) begin
      b  = 1'b1;
      s  = ((t % p) < PC);
      lf = left_at(t, n, p);
    end else begin
      dn = (t == n * p);
    end
    return {s, b, dn, d, 16'(lf)};
  endfunction

  function automatic logic [19:0] sample();
    return {step, busy, done, dir, steps_left};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; abort = 1'b0; dir_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drives one command starting at cycle 0 and records outputs per cycle.
  task automatic run_cmd(input int per, input int n, input bit d, input int abort_c,
                         input int start2_c, input bit d2, input int reset_c, input int len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      start  = (c == 0) || (c == start2_c);
      abort  = (c == abort_c);
      reset  = (c == reset_c);
      dir_in = (c == start2_c) ? d2 : d;
      period = CNT_W'(per);
      steps  = STEP_W'(n);
      @(negedge clk);
      obs[c] = sample();
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; reset = 1'b0; dir_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got;
    do_reset();
    run_cmd(10, 3, 1'b1, NONE, NONE, 1'b0, NONE, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b1; abort = 1'b1; dir_in = 1'b1;
      @(negedge clk);
      got = sample();
      if (i > 0) begin
        checks++;
        if (got !== 20'h0) begin
          errors++;
          $display("FAIL reset cyc=%0d got=%h exp=%h", i, got, 20'h0);
        end
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; abort = 1'b0; dir_in = 1'b0;
  endtask

  task automatic test_nominal();
    logic [19:0] exp;
    do_reset();
    run_cmd(10, 3, 1'b1, NONE, NONE, 1'b0, NONE, 36);
    for (int c = 0; c < 36; c++) begin
      exp = model(c - 1, 3, peff(10), 1'b1, NONE);
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL nominal c=%0d got=%h exp=%h", c, obs[c], exp);
      end
    end
  endtask

  task automatic test_clamp();
    logic [19:0] exp;
    do_reset();
    run_cmd(2, 2, 1'b0, NONE, NONE, 1'b0, NONE, 15);
    for (int c = 0; c < 15; c++) begin
      exp = model(c - 1, 2, 5, 1'b0, NONE);
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL clamp c=%0d got=%h exp=%h", c, obs[c], exp);
      end
    end
  endtask

  task automatic test_zero_steps();
    logic [19:0] exp;
    do_reset();
    run_cmd(10, 0, 1'b1, NONE, NONE, 1'b0, NONE, 5);
    for (int c = 0; c < 5; c++) begin
      exp = model(c - 1, 0, peff(10), 1'b1, NONE);
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL zero_steps c=%0d got=%h exp=%h", c, obs[c], exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [19:0] exp;
    do_reset();
    run_cmd(10, 3, 1'b0, 12, NONE, 1'b0, NONE, 18);
    for (int c = 0; c < 18; c++) begin
      exp = model(c - 1, 3, 10, 1'b0, 11);
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL abort c=%0d got=%h exp=%h", c, obs[c], exp);
      end
    end
    checks++;
    if (obs[13][15:0] !== 16'd2) begin
      errors++;
      $display("FAIL abort_left got=%0d exp=2", obs[13][15:0]);
    end
  endtask

  task automatic test_ignored_start();
    logic [19:0] exp;
    do_reset();
    run_cmd(10, 3, 1'b0, NONE, 5, 1'b1, NONE, 36);
    for (int c = 0; c < 36; c++) begin
      exp = model(c - 1, 3, 10, 1'b0, NONE);
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL ignored_start c=%0d got=%h exp=%h", c, obs[c], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] exp;
    do_reset();
    run_cmd(10, 3, 1'b1, NONE, 5, 1'b0, 3, 40);
    for (int c = 0; c < 40; c++) begin
      if (c <= 3)      exp = model(c - 1, 3, 10, 1'b1, NONE);
      else if (c <= 5) exp = 20'h0;
      else             exp = model(c - 6, 3, 10, 1'b0, NONE);
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs[c], exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    do_reset();
    run_cmd(7, 2, 1'b0, NONE, 15, 1'b1, NONE, 34);
    for (int c = 0; c < 34; c++) begin
      if (c <= 15) exp = model(c - 1, 2, 7, 1'b0, NONE);
      else         exp = model(c - 16, 2, 7, 1'b1, NONE);
      checks++;
      if (obs[c] !== exp) begin
        errors++;
        $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs[c], exp);
      end
    end
  endtask

  task automatic test_abort_idle();
    logic [19:0] got;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      start  = (c == 0);
      abort  = (c == 0) || (c == 3);
      dir_in = 1'b1;
      period = CNT_W'(10);
      steps  = STEP_W'(2);
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== 20'h0) begin
        errors++;
        $display("FAIL abort_idle c=%0d got=%h exp=%h", c, got, 20'h0);
      end
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; dir_in = 1'b0;
  endtask

  task automatic test_random();
    logic [19:0] exp;
    int per, n, p, ac, ta, len;
    bit d;
    for (int it = 0; it < 12; it++) begin
      per = $urandom_range(0, 16);
      n   = $urandom_range(0, 4);
      d   = 1'($urandom_range(0, 1));
      p   = peff(per);
      ac  = NONE;
      ta  = NONE;
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        ac = $urandom_range(1, n * p);
        ta = ac - 1;
      end
      if (n == 0)         len = 4;
      else if (ac != NONE) len = ac + 3;
      else                len = n * p + 4;
      do_reset();
      run_cmd(per, n, d, ac, NONE, 1'b0, NONE, len);
      for (int c = 0; c < len; c++) begin
        exp = model(c - 1, n, p, d, ta);
        checks++;
        if (obs[c] !== exp) begin
          errors++;
          $display("FAIL random it=%0d per=%0d n=%0d ab=%0d c=%0d got=%h exp=%h",
                   it, per, n, ac, c, obs[c], exp);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; dir_in = 1'b0;
    period = '0; steps = '0;
    test_reset();
    test_nominal();
    test_clamp();
    test_zero_steps();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_abort_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stepper_pulse_sched.md
STEPPER_PULSE_SCHED -- requirements
Module: stepper_pulse_sched

Interface
REQ-001 Parameters SHALL be as follows.
- CNT_W, 28: width of period and timing counter.
- STEP_W, 16: width of step count.
- PULSE_CYC, 100: step pulse high time in clocks, minimum 1.

REQ-002 Ports SHALL be as follows.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  command request, sampled each edge.
- period  in  CNT_W  clocks between successive step rising edges.
- steps  in  STEP_W  number of step pulses to issue.
- dir_in  in  1  direction for the command.
- abort  in  1  terminate the active command.
- step  out  1  step pulse to motor driver.
- dir  out  1  latched direction.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion strobe.
- steps_left  out  STEP_W  pulses not yet completed.

REQ-003 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high, named reset.

Function
REQ-004 FSM states SHALL be IDLE, HIGH and LOW; busy=1 exactly when the state is HIGH or LOW.
REQ-005 In IDLE, start=1 and abort=0 SHALL accept a command: latch period, steps and dir_in (dir updates only here).
REQ-006 Effective period SHALL be P_eff = max(period, PULSE_CYC+1), computed unsigned at CNT_W bits and latched at accept.
REQ-007 Accept with steps=0 SHALL stay in IDLE, assert done for 1 cycle at edge k+1, and emit no step.
REQ-008 Accept at edge k with steps>0 SHALL enter HIGH at edge k+1 with step=1, busy=1 and steps_left=steps.
REQ-009 HIGH SHALL last exactly PULSE_CYC cycles, then go to LOW with step=0, and steps_left SHALL decrement on that transition.
REQ-010 LOW SHALL last exactly P_eff-PULSE_CYC cycles, so consecutive step rising edges are exactly P_eff cycles apart.
REQ-011 At the end of LOW:
- steps_left>0: go to HIGH.
- steps_left=0: go to IDLE and assert done for 1 cycle in the first IDLE cycle.
REQ-012 Done timing: done SHALL occur at cycle k+1+steps*P_eff; the final LOW phase is always served in full.
REQ-013 start while busy=1 SHALL be ignored; start in the done cycle SHALL be accepted (state is IDLE).
REQ-014 abort while busy SHALL, at the next edge:
- go to IDLE;
- force step=0;
- assert done for 1 cycle;
- leave steps_left unchanged (a truncated pulse is not counted).
REQ-015 abort SHALL take priority over start; abort in IDLE SHALL be ignored.
REQ-016 The internal timer SHALL be CNT_W bits, cleared on every state entry, and SHALL never wrap within a phase.
REQ-017 step, busy and done SHALL be registered outputs, glitch-free.

Reset
REQ-018 reset SHALL force the following at the next edge: state IDLE, step=0, busy=0, done=0, dir=0, steps_left=0, timer=0.
REQ-019 reset SHALL override start and abort.
REQ-020 reset mid-command SHALL drop step at the next edge with no done pulse; the first non-reset cycle SHALL accept start.

Verification (PULSE_CYC=4)
REQ-021 Nominal: start, steps=3, period=10 at edge 0 -> step high cycles 1-4, 11-14, 21-24; steps_left 3->2->1->0 at edges 5, 15, 25; done at 31.
REQ-022 Clamp: steps=2, period=2 -> P_eff=5; step high cycles 1-4 and 6-9; done at 11.
REQ-023 Zero steps: steps=0 -> done at cycle 1; busy and step never high.
REQ-024 Abort: steps=3, period=10; abort at cycle 12 -> step=0 and busy=0 from cycle 13; done at 13; steps_left=2.
REQ-025 Ignored start: second start (dir_in=1) at cycle 5 during a dir=0 command -> dir stays 0 and the timing of REQ-021 is unchanged.
REQ-026 Reset mid-operation: reset at cycle 3 -> all outputs 0 at cycle 4, no done pulse; start at cycle 5 -> step=1 at 6.
